// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the switch debounce bank.
package debounce_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd250000;

  // Counter width for a given stability window; never narrower than one bit.
  function automatic int unsigned counter_width(input int unsigned cycles);
    int unsigned width_v;
    width_v = 32'd1;
    if (cycles > 32'd2) begin
      width_v = 32'($clog2(cycles));
    end else begin
      width_v = 32'd1;
    end
    return width_v;
  endfunction

  function automatic int unsigned cycles_from_ms(input longint unsigned clk_hz,
                                                 input int unsigned ms);
    longint unsigned prod_v;
    prod_v = (clk_hz * 64'(ms)) / 64'd1000;
    return 32'(prod_v);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser, stability counter, clean level,
// press/release strobes and a toggle register.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          TOGGLE_ON_RELEASE = 1'b1,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch_Clean,
  output logic o_Press,
  output logic o_Release,
  output logic o_Toggle
);

  localparam int unsigned     CW       = counter_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic [1:0]    sync_r;
  logic [CW-1:0] count_r;
  logic          clean_r;
  logic          press_r;
  logic          release_r;
  logic          toggle_r;
  logic          level_s;
  logic          accept_s;
  logic          flip_s;

  // Polarity-normalised level and the acceptance/toggle decisions.
  always_comb begin
    level_s  = sync_r[1] ^ ACTIVE_LOW;
    accept_s = (level_s != clean_r) && (count_r == CNT_LAST);
    flip_s   = TOGGLE_ON_RELEASE ? (accept_s && !level_s) : (accept_s && level_s);
  end

  // Synchroniser, stability counter and all registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_r    <= 2'b00;
      count_r   <= {CW{1'b0}};
      clean_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      toggle_r  <= 1'b0;
    end else begin
      sync_r    <= {sync_r[0], i_Switch};
      press_r   <= accept_s && level_s;
      release_r <= accept_s && !level_s;
      if (level_s == clean_r) begin
        count_r <= {CW{1'b0}};
      end else if (accept_s) begin
        clean_r <= level_s;
        count_r <= {CW{1'b0}};
      end else begin
        count_r <= count_r + CW'(1);
      end
      if (flip_s) begin
        toggle_r <= ~toggle_r;
      end else begin
        toggle_r <= toggle_r;
      end
    end
  end

  assign o_Switch_Clean = clean_r;
  assign o_Press        = press_r;
  assign o_Release      = release_r;
  assign o_Toggle       = toggle_r;

endmodule

// File: rtl/debounce_toggle_bank.sv
// Bank of NUM_SW independent debounced switch channels with toggle outputs.
module debounce_toggle_bank
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_SW            = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          TOGGLE_ON_RELEASE = 1'b1,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch_Clean,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic [NUM_SW-1:0] o_Toggle
);

  for (genvar ch = 0; ch < NUM_SW; ch++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .TOGGLE_ON_RELEASE(TOGGLE_ON_RELEASE),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_chan (
      .i_Clk         (i_Clk),
      .i_Reset       (i_Reset),
      .i_Switch      (i_Switch[ch]),
      .o_Switch_Clean(o_Switch_Clean[ch]),
      .o_Press       (o_Press[ch]),
      .o_Release     (o_Release[ch]),
      .o_Toggle      (o_Toggle[ch])
    );
  end

endmodule

// File: tb/tb_debounce_toggle_bank.sv
// Self-checking bench: three configurations (release-toggle, press-toggle,
// active-low) against a run-length reference model, plus directed sequences.
module tb_debounce_toggle_bank;

  localparam int DEB  = 4;
  localparam int NSW  = 4;
  localparam int LOGN = 64;
  localparam bit [2:0] CFG_TOR = 3'b101;
  localparam bit [2:0] CFG_AL  = 3'b100;

  logic           i_Clk = 1'b0;
  logic           rst   = 1'b1;
  logic [NSW-1:0] sw    = '0;
  logic [NSW-1:0] sw_al = '1;
  logic [NSW-1:0] o_clean [3];
  logic [NSW-1:0] o_press [3];
  logic [NSW-1:0] o_rel   [3];
  logic [NSW-1:0] o_tog   [3];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 i_Clk = ~i_Clk;

  debounce_toggle_bank #(.NUM_SW(NSW), .DEBOUNCE_CYCLES(DEB), .TOGGLE_ON_RELEASE(1'b1), .ACTIVE_LOW(1'b0)) dut_rel (
    .i_Clk(i_Clk), .i_Reset(rst), .i_Switch(sw),
    .o_Switch_Clean(o_clean[0]), .o_Press(o_press[0]), .o_Release(o_rel[0]), .o_Toggle(o_tog[0]));
  debounce_toggle_bank #(.NUM_SW(NSW), .DEBOUNCE_CYCLES(DEB), .TOGGLE_ON_RELEASE(1'b0), .ACTIVE_LOW(1'b0)) dut_prs (
    .i_Clk(i_Clk), .i_Reset(rst), .i_Switch(sw),
    .o_Switch_Clean(o_clean[1]), .o_Press(o_press[1]), .o_Release(o_rel[1]), .o_Toggle(o_tog[1]));
  debounce_toggle_bank #(.NUM_SW(NSW), .DEBOUNCE_CYCLES(DEB), .TOGGLE_ON_RELEASE(1'b1), .ACTIVE_LOW(1'b1)) dut_al (
    .i_Clk(i_Clk), .i_Reset(rst), .i_Switch(sw_al),
    .o_Switch_Clean(o_clean[2]), .o_Press(o_press[2]), .o_Release(o_rel[2]), .o_Toggle(o_tog[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the synchronised input has held
  // one value (differing from the clean level) for DEB consecutive edges.
  logic [NSW-1:0] m_clean [3];
  logic [NSW-1:0] m_press [3];
  logic [NSW-1:0] m_rel   [3];
  logic [NSW-1:0] m_tog   [3];
  int             run     [3][NSW];
  logic           last_s  [3][NSW];
  logic [NSW-1:0] pin_log    [LOGN];
  logic [NSW-1:0] pin_log_al [LOGN];
  int edge_n   = 0;
  int rst_edge = 0;

  task automatic model_step();
    logic [NSW-1:0] pins;
    logic s;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_clean[c] = '0; m_press[c] = '0; m_rel[c] = '0; m_tog[c] = '0;
        for (int ch = 0; ch < NSW; ch++) begin
          run[c][ch] = 0; last_s[c][ch] = 1'b0;
        end
      end
      rst_edge = edge_n;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (edge_n - 2 > rst_edge)
          pins = (c == 2) ? pin_log_al[(edge_n - 2) % LOGN] : pin_log[(edge_n - 2) % LOGN];
        else
          pins = '0;
        for (int ch = 0; ch < NSW; ch++) begin
          s = pins[ch] ^ CFG_AL[c];
          if (run[c][ch] > 0 && s == last_s[c][ch]) run[c][ch]++;
          else run[c][ch] = 1;
          last_s[c][ch] = s;
          m_press[c][ch] = 1'b0;
          m_rel[c][ch]   = 1'b0;
          if (s != m_clean[c][ch] && run[c][ch] >= DEB) begin
            m_clean[c][ch] = s;
            m_press[c][ch] = s;
            m_rel[c][ch]   = !s;
            if (CFG_TOR[c] ? !s : s) m_tog[c][ch] = ~m_tog[c][ch];
          end
        end
      end
    end
    pin_log[edge_n % LOGN]    = sw;
    pin_log_al[edge_n % LOGN] = sw_al;
    edge_n++;
  endtask

  always @(posedge i_Clk) model_step();

  always @(negedge i_Clk) begin
    if (chk_en) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("model_clean_cfg%0d", c), 32'(o_clean[c]), 32'(m_clean[c]));
        chk($sformatf("model_press_cfg%0d", c), 32'(o_press[c]), 32'(m_press[c]));
        chk($sformatf("model_release_cfg%0d", c), 32'(o_rel[c]), 32'(m_rel[c]));
        chk($sformatf("model_toggle_cfg%0d", c), 32'(o_tog[c]), 32'(m_tog[c]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NSW-1:0] sw;
    int             hold;
    logic [NSW-1:0] clean;
    logic [NSW-1:0] tog_rel;
    logic [NSW-1:0] tog_prs;
  } vec_t;

  vec_t tbl [7];
  int   cnt;
  int   idx;
  logic [NSW-1:0] bounce_v [5];

  initial begin
    tbl[0] = '{4'b0001, 8, 4'b0001, 4'b0000, 4'b0001};
    tbl[1] = '{4'b0000, 8, 4'b0000, 4'b0001, 4'b0001};
    tbl[2] = '{4'b1111, 8, 4'b1111, 4'b0001, 4'b1110};
    tbl[3] = '{4'b1010, 8, 4'b1010, 4'b0100, 4'b1110};
    tbl[4] = '{4'b0000, 8, 4'b0000, 4'b1110, 4'b1110};
    tbl[5] = '{4'b0101, 3, 4'b0000, 4'b1110, 4'b1110};
    tbl[6] = '{4'b0000, 8, 4'b0000, 4'b1110, 4'b1110};

    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < 3; c++)
      chk($sformatf("reset_state_cfg%0d", c), 32'({o_clean[c], o_press[c], o_rel[c], o_tog[c]}), 32'd0);

    for (int i = 0; i < 7; i++) begin
      sw = tbl[i].sw;
      tick(tbl[i].hold);
      chk($sformatf("tbl%0d_clean", i), 32'(o_clean[0]), 32'(tbl[i].clean));
      chk($sformatf("tbl%0d_tog_rel", i), 32'(o_tog[0]), 32'(tbl[i].tog_rel));
      chk($sformatf("tbl%0d_tog_prs", i), 32'(o_tog[1]), 32'(tbl[i].tog_prs));
    end

    // Clean press then release on ch0.
    do_reset();
    sw[0] = 1'b1;
    tick(5);
    chk("press_clean_early", 32'(o_clean[0][0]), 32'd0);
    tick(1);
    chk("press_clean_at6", 32'(o_clean[0][0]), 32'd1);
    chk("press_strobe", 32'(o_press[0]), 32'b0001);
    cnt = 0;
    for (int k = 0; k < 19; k++) begin
      tick(1);
      cnt += int'(o_press[0][0]);
    end
    chk("press_single_pulse", 32'(cnt), 32'd0);
    chk("press_no_toggle", 32'(o_tog[0][0]), 32'd0);
    sw[0] = 1'b0;
    tick(6);
    chk("release_strobe", 32'(o_rel[0]), 32'b0001);
    chk("release_toggle", 32'(o_tog[0][0]), 32'd1);
    tick(1);
    chk("release_strobe_end", 32'(o_rel[0][0]), 32'd0);

    // Bounce on ch1 then a stable high.
    do_reset();
    bounce_v = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
    cnt = 0;
    for (int b = 0; b < 4; b++) begin
      sw = bounce_v[b];
      for (int k = 0; k < 2; k++) begin
        tick(1);
        cnt += int'(o_press[0][1]) + int'(o_rel[0][1]);
      end
    end
    chk("bounce_no_strobe", 32'(cnt), 32'd0);
    sw = bounce_v[4];
    tick(5);
    chk("bounce_clean_early", 32'(o_clean[0][1]), 32'd0);
    tick(1);
    chk("bounce_clean_at6", 32'(o_clean[0][1]), 32'd1);
    cnt = int'(o_press[0][1]);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      cnt += int'(o_press[0][1]);
    end
    chk("bounce_one_press", 32'(cnt), 32'd1);

    // Three-cycle glitch on ch2.
    sw[2] = 1'b1;
    tick(3);
    sw[2] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      cnt += int'(o_clean[0][2]) + int'(o_press[0][2]) + int'(o_rel[0][2]) + int'(o_tog[0][2]);
    end
    chk("glitch_ignored", 32'(cnt), 32'd0);
    sw = '0;

    // All channels pressed together.
    do_reset();
    sw = 4'b1111;
    tick(5);
    chk("all_press_early", 32'(o_press[0]), 32'd0);
    tick(1);
    chk("all_press_rel_cfg", 32'(o_press[0]), 32'b1111);
    chk("all_press_prs_cfg", 32'(o_press[1]), 32'b1111);
    chk("all_press_toggle_prs", 32'(o_tog[1]), 32'b1111);
    chk("all_press_toggle_rel", 32'(o_tog[0]), 32'b0000);
    sw = '0;
    tick(10);

    // Reset two cycles into ch3's debounce.
    do_reset();
    sw[3] = 1'b1;
    tick(4);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      for (int c = 0; c < 3; c++)
        chk($sformatf("midreset_zero_cfg%0d", c), 32'({o_clean[c], o_press[c], o_rel[c], o_tog[c]}), 32'd0);
    end
    rst = 1'b0;
    tick(5);
    chk("postreset_clean_early", 32'(o_clean[0][3]), 32'd0);
    tick(1);
    chk("postreset_clean_at6", 32'(o_clean[0][3]), 32'd1);
    chk("postreset_press", 32'(o_press[0]), 32'b1000);
    sw = '0;
    tick(10);

    // Active-low channel.
    do_reset();
    tick(8);
    chk("al_idle_clean", 32'(o_clean[2]), 32'd0);
    sw_al[0] = 1'b0;
    tick(5);
    chk("al_press_early", 32'(o_press[2]), 32'd0);
    tick(1);
    chk("al_press", 32'(o_press[2]), 32'b0001);
    chk("al_clean", 32'(o_clean[2]), 32'b0001);
    sw_al = '1;
    tick(10);

    // Randomised traffic, checked every cycle against the model.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, NSW - 1));
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, NSW - 1));
        sw_al[idx] = ~sw_al[idx];
      end
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
